// File: rtl/if_stage.sv
// RV32I instruction-fetch stage.
// Holds the PC, the PC+4 adder and the IF/ID register.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        PCWrite,
  input  logic        IFIDWrite,
  input  logic        Flush,
  input  logic [31:0] BranchTarget,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] IFID_PC,
  output logic [31:0] IFID_PC4,
  output logic [31:0] IFID_Instr,
  output logic        IFID_Valid,
  output logic [4:0]  IFID_RegisterR1,
  output logic [4:0]  IFID_RegisterR2,
  output logic [15:0] StallCount
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        valid;
  } if_id_t;

  localparam logic [31:0] W_ALIGN = 32'hFFFF_FFFC;

  logic [31:0] r_pc;
  if_id_t      r_ifid;
  logic [15:0] r_stall_cnt;

  logic [31:0] w_target;
  logic [31:0] w_pc_next4;

  assign w_target   = BranchTarget & W_ALIGN;
  assign w_pc_next4 = r_pc + 32'd4;

  // PC and IF/ID: reset, then flush, then per-field stall/advance
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_pc         <= RESET_PC & W_ALIGN;
      r_ifid.pc    <= 32'd0;
      r_ifid.instr <= NOP_INSTR;
      r_ifid.valid <= 1'b0;
    end else if (Flush) begin
      r_pc         <= w_target;
      r_ifid.instr <= NOP_INSTR;
      r_ifid.valid <= 1'b0;
    end else begin
      if (PCWrite) begin
        r_pc <= w_pc_next4;
      end
      if (IFIDWrite) begin
        r_ifid.pc    <= r_pc;
        r_ifid.instr <= imem_data;
        r_ifid.valid <= 1'b1;
      end
    end
  end

  // Saturating count of PC-hold cycles not caused by a flush
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_stall_cnt <= 16'd0;
    end else if (!PCWrite && !Flush &&
                 (r_stall_cnt != 16'hFFFF)) begin
      r_stall_cnt <= r_stall_cnt + 16'd1;
    end
  end

  assign imem_addr       = r_pc;
  assign IFID_PC         = r_ifid.pc;
  assign IFID_PC4        = r_ifid.pc + 32'd4;
  assign IFID_Instr      = r_ifid.instr;
  assign IFID_Valid      = r_ifid.valid;
  assign IFID_RegisterR1 = r_ifid.instr[19:15];
  assign IFID_RegisterR2 = r_ifid.instr[24:20];
  assign StallCount      = r_stall_cnt;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage.
// Vector table plus a long stall-count saturation run.
module tb_if_stage;

  logic        clk;
  logic        reset_n;
  logic        PCWrite;
  logic        IFIDWrite;
  logic        Flush;
  logic [31:0] BranchTarget;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] IFID_PC;
  logic [31:0] IFID_PC4;
  logic [31:0] IFID_Instr;
  logic        IFID_Valid;
  logic [4:0]  IFID_RegisterR1;
  logic [4:0]  IFID_RegisterR2;
  logic [15:0] StallCount;

  logic        add4;
  int          checks;
  int          failures;

  localparam logic [31:0] ADD = 32'h0051_8233;
  localparam logic [31:0] NOP = 32'h0000_0013;

  if_stage dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .PCWrite         (PCWrite),
    .IFIDWrite       (IFIDWrite),
    .Flush           (Flush),
    .BranchTarget    (BranchTarget),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .IFID_PC         (IFID_PC),
    .IFID_PC4        (IFID_PC4),
    .IFID_Instr      (IFID_Instr),
    .IFID_Valid      (IFID_Valid),
    .IFID_RegisterR1 (IFID_RegisterR1),
    .IFID_RegisterR2 (IFID_RegisterR2),
    .StallCount      (StallCount)
  );

  // ROM word = address, optionally an add at address 4
  assign imem_data = (add4 && imem_addr == 32'd4) ?
                     ADD : imem_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst_n;
    logic        pcw;
    logic        ifw;
    logic        fl;
    logic        a4;
    logic [31:0] tgt;
    logic [31:0] e_addr;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    logic        e_v;
    logic [15:0] e_cnt;
  } vec_t;

  function automatic vec_t mk(
    input logic r, input logic pw, input logic iw,
    input logic f, input logic a, input logic [31:0] t,
    input logic [31:0] ea, input logic [31:0] ep,
    input logic [31:0] ei, input logic ev,
    input logic [15:0] ec);
    vec_t v;
    v.rst_n = r;  v.pcw = pw; v.ifw = iw;
    v.fl = f;     v.a4 = a;   v.tgt = t;
    v.e_addr = ea; v.e_pc = ep; v.e_ins = ei;
    v.e_v = ev;   v.e_cnt = ec;
    return v;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic pw,
                       input logic iw, input logic f,
                       input logic [31:0] t);
    reset_n = r; PCWrite = pw; IFIDWrite = iw;
    Flush = f; BranchTarget = t;
  endtask

  vec_t vt[22];

  initial begin
    logic [31:0] e4;
    checks = 0;
    failures = 0;
    add4 = 1'b0;
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);

    // rst pw iw fl a4 tgt | addr pc instr v cnt
    vt[0]  = mk(0,1,1,0,0,0, 0,0,NOP,0,0);
    vt[1]  = mk(0,1,1,0,0,0, 0,0,NOP,0,0);
    vt[2]  = mk(1,1,1,0,0,0, 4,0,0,1,0);
    vt[3]  = mk(1,1,1,0,0,0, 8,4,4,1,0);
    vt[4]  = mk(1,1,1,0,0,0, 12,8,8,1,0);
    vt[5]  = mk(1,1,1,0,0,0, 16,12,12,1,0);
    vt[6]  = mk(0,1,1,0,1,0, 0,0,NOP,0,0);
    vt[7]  = mk(1,1,1,0,1,0, 4,0,0,1,0);
    vt[8]  = mk(1,1,1,0,1,0, 8,4,ADD,1,0);
    vt[9]  = mk(1,0,0,0,1,0, 8,4,ADD,1,1);
    vt[10] = mk(1,1,1,0,1,0, 12,8,8,1,1);
    vt[11] = mk(1,1,1,0,1,0, 16,12,12,1,1);
    vt[12] = mk(1,1,1,0,1,0, 20,16,16,1,1);
    vt[13] = mk(1,1,1,1,1,32'h43, 32'h40,16,NOP,0,1);
    vt[14] = mk(1,1,1,0,1,0, 32'h44,32'h40,32'h40,1,1);
    vt[15] = mk(1,0,0,1,1,32'h100,
                32'h100,32'h40,NOP,0,1);
    vt[16] = mk(1,1,1,1,1,32'hFFFF_FFFC,
                32'hFFFF_FFFC,32'h40,NOP,0,1);
    vt[17] = mk(1,1,1,0,1,0, 0,32'hFFFF_FFFC,
                32'hFFFF_FFFC,1,1);
    vt[18] = mk(1,1,1,0,1,0, 4,0,0,1,1);
    vt[19] = mk(0,0,0,1,1,32'h200, 0,0,NOP,0,0);
    vt[20] = mk(1,1,0,0,0,0, 4,0,NOP,0,0);
    vt[21] = mk(1,0,1,0,0,0, 4,4,4,1,1);

    for (int i = 0; i < 22; i++) begin
      drive(vt[i].rst_n, vt[i].pcw, vt[i].ifw,
            vt[i].fl, vt[i].tgt);
      add4 = vt[i].a4;
      @(posedge clk);
      #1;
      e4 = vt[i].e_pc + 32'd4;
      chk($sformatf("v%0d addr", i), imem_addr, vt[i].e_addr);
      chk($sformatf("v%0d pc", i), IFID_PC, vt[i].e_pc);
      chk($sformatf("v%0d pc4", i), IFID_PC4, e4);
      chk($sformatf("v%0d instr", i), IFID_Instr, vt[i].e_ins);
      chk($sformatf("v%0d valid", i),
          {31'd0, IFID_Valid}, {31'd0, vt[i].e_v});
      chk($sformatf("v%0d rs1", i), {27'd0, IFID_RegisterR1},
          {27'd0, vt[i].e_ins[19:15]});
      chk($sformatf("v%0d rs2", i), {27'd0, IFID_RegisterR2},
          {27'd0, vt[i].e_ins[24:20]});
      chk($sformatf("v%0d cnt", i), {16'd0, StallCount},
          {16'd0, vt[i].e_cnt});
    end

    // Hand sequence: reset, then long stall to saturate counter
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    @(posedge clk);
    #1;
    chk("sat rst cnt", {16'd0, StallCount}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
    for (int c = 1; c <= 70000; c++) begin
      @(posedge clk);
      #1;
      if (c == 65534)
        chk("sat cnt fffe", {16'd0, StallCount}, 32'hFFFE);
      if (c == 65535)
        chk("sat cnt ffff", {16'd0, StallCount}, 32'hFFFF);
    end
    chk("sat cnt hold", {16'd0, StallCount}, 32'hFFFF);
    chk("sat pc hold", imem_addr, 32'd0);
    chk("sat ifid hold", IFID_Instr, NOP);

    drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h80);
    @(posedge clk);
    #1;
    chk("sat flush cnt", {16'd0, StallCount}, 32'hFFFF);
    chk("sat flush pc", imem_addr, 32'h80);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
